// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter that funnels instruction-cache miss requests from
// NUM_CHANNELS requesters onto one shared backing-memory read port.
// One transaction is in flight at a time: IDLE -> REQUEST -> RESPOND -> IDLE.
//
// Handshake semantics (both sides): a requester raises valid with a stable
// address and holds both until the matching ready pulse; the transfer
// completes at the edge where ready=1 is sampled. On the memory side,
// mem_read_valid stays high with a stable address until mem_read_ready=1 is
// sampled in REQUEST; mem_read_ready outside REQUEST is ignored.
module icache_mem_arbiter #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int ID_BITS      = $clog2(NUM_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           cache_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] cache_read_address,
    output logic [NUM_CHANNELS-1:0]           cache_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] cache_read_data,
    output logic                              mem_read_valid,
    output logic [ADDR_BITS-1:0]              mem_read_address,
    input  logic                              mem_read_ready,
    input  logic [DATA_BITS-1:0]              mem_read_data,
    output logic                              busy,
    output logic [ID_BITS-1:0]                grant_id,
    output logic [1:0]                        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_BITS-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]       grant_id_q, grant_id_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic                     mem_valid_q, mem_valid_d;
    logic [NUM_CHANNELS-1:0]  ready_q, ready_d;
    logic                     busy_q, busy_d;

    logic                     arb_found;
    logic [ID_BITS-1:0]       arb_idx;
    logic [ID_BITS-1:0]       arb_next;

    // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            int c;
            c = int'(rr_ptr_q) + i;
            if (c >= NUM_CHANNELS) c = c - NUM_CHANNELS;
            if (!arb_found && cache_read_valid[c]) begin
                arb_found = 1'b1;
                arb_idx   = ID_BITS'(c);
            end
        end
        if (arb_idx == ID_BITS'(NUM_CHANNELS - 1)) arb_next = '0;
        else                                       arb_next = arb_idx + 1'b1;
    end

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        data_d      = data_q;
        addr_d      = addr_q;
        mem_valid_d = mem_valid_q;
        ready_d     = '0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d     = S_REQUEST;
                    grant_id_d  = arb_idx;
                    rr_ptr_d    = arb_next;
                    addr_d      = cache_read_address[arb_idx*ADDR_BITS +: ADDR_BITS];
                    mem_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_REQUEST: begin
                // Requester valid changes are ignored here; wait on memory only.
                if (mem_read_ready) begin
                    state_d              = S_RESPOND;
                    data_d               = mem_read_data;
                    mem_valid_d          = 1'b0;
                    ready_d[grant_id_q]  = 1'b1;
                end
            end
            S_RESPOND: begin
                // One-cycle completion pulse; a trailing memory strobe is dropped.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that also aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            mem_valid_q <= 1'b0;
            ready_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            mem_valid_q <= mem_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cache_read_ready = ready_q;
    assign cache_read_data  = {NUM_CHANNELS{data_q}};
    assign mem_read_valid   = mem_valid_q;
    assign mem_read_address = addr_q;
    assign busy             = busy_q;
    assign grant_id         = grant_id_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed bench for icache_mem_arbiter: a responding memory model
// (2*addr+1 after a programmable delay, optional trailing strobe), requesters
// that drop valid on their ready pulse, and a scoreboard of expected
// {channel, data} completions in grant order.
module tb_icache_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 2;
    localparam int W  = IW + DW;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     cache_read_valid;
    logic [NC*AW-1:0]  cache_read_address;
    logic [NC-1:0]     cache_read_ready;
    logic [NC*DW-1:0]  cache_read_data;
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_address;
    logic              mem_read_ready;
    logic [DW-1:0]     mem_read_data;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [1:0]        state_dbg;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [W-1:0] exp_q[$];

    // memory model controls
    logic mem_auto   = 1'b0;
    int   mem_extra  = 0;
    logic mem_trail  = 1'b0;
    int   mem_cnt    = 0;
    logic mem_trailed = 1'b0;
    logic mon_en     = 1'b0;

    icache_mem_arbiter #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NC), .ID_BITS(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .cache_read_valid(cache_read_valid),
        .cache_read_address(cache_read_address),
        .cache_read_ready(cache_read_ready),
        .cache_read_data(cache_read_data),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .busy(busy),
        .grant_id(grant_id),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input int k, input logic [AW-1:0] a);
        cache_read_address[k*AW +: AW] = a;
        cache_read_valid[k] = 1'b1;
    endtask

    function automatic logic [W-1:0] exp_item(input int k, input logic [DW-1:0] d);
        logic [IW-1:0] kk;
        kk = IW'(k);
        return {kk, d};
    endfunction

    // memory model: responds 2*addr+1, strobe sampled (mem_extra+2) edges after valid rises
    initial begin
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (mem_read_valid) begin
                    mem_cnt++;
                    if (mem_cnt == mem_extra + 2) begin
                        mem_read_ready = 1'b1;
                        mem_read_data  = (DW'(mem_read_address) << 1) + 16'd1;
                    end else begin
                        mem_read_ready = 1'b0;
                    end
                end else begin
                    mem_cnt = 0;
                    if (mem_trail && mem_read_ready && !mem_trailed) begin
                        mem_trailed = 1'b1;
                    end else begin
                        mem_read_ready = 1'b0;
                        mem_trailed    = 1'b0;
                    end
                end
            end
        end
    end

    // monitor, requester drop and scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("ready_onehot", 64'($countones(cache_read_ready) <= 1), 64'd1);
                check("mem_valid_while_idle", 64'(mem_read_valid && !busy), 64'd0);
                check("mem_valid_with_ready", 64'(mem_read_valid && (|cache_read_ready)), 64'd0);
                if (|cache_read_ready) begin
                    int k;
                    logic [DW-1:0] lane;
                    k = 0;
                    for (int i = 0; i < NC; i++) if (cache_read_ready[i]) k = i;
                    lane = cache_read_data[k*DW +: DW];
                    check("lanes_equal", 64'(cache_read_data), 64'({NC{lane}}));
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 64'(cache_read_ready), 64'd0);
                    end else begin
                        check("completion_ch_data", 64'(exp_item(k, lane)), 64'(exp_q.pop_front()));
                    end
                    cache_read_valid[k] = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input string tag, input int budget);
        int n;
        logic done;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        done = (exp_q.size() == 0) && !busy;
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // directed sequence
    initial begin
        int n;
        reset              = 1'b1;
        cache_read_valid   = '0;
        cache_read_address = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_valid", 64'(mem_read_valid), 64'd0);
        check("rst_ready", 64'(cache_read_ready), 64'd0);
        check("rst_data", 64'(cache_read_data), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_addr", 64'(mem_read_address), 64'd0);
        reset    = 1'b0;
        mem_auto = 1'b1;
        mon_en   = 1'b1;
        step();

        // single request, minimum latency
        exp_q.push_back(exp_item(0, 16'h000B));
        req(0, 8'h05);
        step();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_mem_valid", 64'(mem_read_valid), 64'd1);
        check("t1_mem_addr", 64'(mem_read_address), 64'h05);
        check("t1_grant", 64'(grant_id), 64'd0);
        step();
        check("t1_no_ready_e1", 64'(cache_read_ready), 64'd0);
        step();
        check("t1_ready_e2", 64'(cache_read_ready), 64'b0001);
        check("t1_lane0", 64'(cache_read_data[0 +: DW]), 64'h000B);
        step();
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_ready_clear", 64'(cache_read_ready), 64'd0);

        // all four channels at once right after reset
        do_reset();
        exp_q.push_back(exp_item(0, 16'h0021));
        exp_q.push_back(exp_item(1, 16'h0041));
        exp_q.push_back(exp_item(2, 16'h0061));
        exp_q.push_back(exp_item(3, 16'h0081));
        req(0, 8'h10); req(1, 8'h20); req(2, 8'h30); req(3, 8'h40);
        step();
        check("t2_first_grant", 64'(grant_id), 64'd0);
        wait_done("t2_done", 40);

        // ch2 alone, then ch1+ch3 together: rr_ptr=3 so ch3 first
        exp_q.push_back(exp_item(2, 16'h0005));
        req(2, 8'h02);
        wait_done("t3a_done", 20);
        exp_q.push_back(exp_item(3, 16'h0067));
        exp_q.push_back(exp_item(1, 16'h0023));
        req(1, 8'h11); req(3, 8'h33);
        step();
        check("t3_grant_ch3", 64'(grant_id), 64'd3);
        wait_done("t3b_done", 30);

        // slow memory: strobe held off, request stays stable
        mem_extra = 5;
        exp_q.push_back(exp_item(0, 16'h0089));
        req(0, 8'h44);
        n = 0;
        while (!(|cache_read_ready) && n < 30) begin
            step();
            n++;
            if (!(|cache_read_ready)) begin
                check("t4_hold_valid", 64'(mem_read_valid), 64'd1);
                check("t4_hold_addr", 64'(mem_read_address), 64'h44);
                check("t4_hold_busy", 64'(busy), 64'd1);
            end
        end
        check("t4_latency", 64'(n), 64'd8);
        wait_done("t4_done", 10);
        mem_extra = 0;

        // trailing strobe during RESPOND is ignored
        mem_trail = 1'b1;
        exp_q.push_back(exp_item(2, 16'h000D));
        req(2, 8'h06);
        n = 0;
        while (!(|cache_read_ready) && n < 20) begin
            step();
            n++;
        end
        check("t5_pulse", 64'(cache_read_ready), 64'b0100);
        step();
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_no_extra", 64'(cache_read_ready), 64'd0);
        step();
        check("t5_no_extra2", 64'(cache_read_ready), 64'd0);
        check("t5_still_idle", 64'(busy), 64'd0);
        mem_trail = 1'b0;

        // reset while in REQUEST aborts; next search restarts at channel 0
        mem_extra = 20;
        req(1, 8'h15);
        step();
        check("t6_grant_ch1", 64'(grant_id), 64'd1);
        check("t6_busy", 64'(busy), 64'd1);
        step();
        reset = 1'b1;
        step();
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_mem_valid", 64'(mem_read_valid), 64'd0);
        check("t6_rst_ready", 64'(cache_read_ready), 64'd0);
        check("t6_rst_data", 64'(cache_read_data), 64'd0);
        check("t6_rst_addr", 64'(mem_read_address), 64'd0);
        reset            = 1'b0;
        cache_read_valid = '0;
        mem_auto         = 1'b0;
        mem_read_ready   = 1'b1;
        mem_read_data    = 16'hDEAD;
        step();
        check("t6_stray_busy", 64'(busy), 64'd0);
        check("t6_stray_ready", 64'(cache_read_ready), 64'd0);
        mem_read_ready = 1'b0;
        step();
        check("t6_stray_ready2", 64'(cache_read_ready), 64'd0);
        mem_cnt   = 0;
        mem_extra = 0;
        mem_auto  = 1'b1;
        exp_q.push_back(exp_item(1, 16'h002B));
        exp_q.push_back(exp_item(3, 16'h006B));
        req(1, 8'h15); req(3, 8'h35);
        step();
        check("t6_regrant_ch1", 64'(grant_id), 64'd1);
        wait_done("t6_done", 30);

        step();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_mem_arbiter.md
ICACHE_MEM_ARBITER -- requirements
Module: icache_mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 8, width of memory addresses.
REQ-002 Parameter DATA_BITS, default 16, width of memory data words.
REQ-003 Parameter NUM_CHANNELS, default 4, number of cache requesters; legal range 2..16.
REQ-004 Parameter ID_BITS, default $clog2(NUM_CHANNELS), width of grant_id.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cache_read_valid  input  NUM_CHANNELS  per-channel miss request; bit k = channel k.
REQ-008 cache_read_address  input  NUM_CHANNELS*ADDR_BITS  per-channel address; channel k at bits [k*ADDR_BITS +: ADDR_BITS].
REQ-009 cache_read_ready  output  NUM_CHANNELS  per-channel one-cycle completion pulse.
REQ-010 cache_read_data  output  NUM_CHANNELS*DATA_BITS  per-channel returned word, same lane packing as addresses.
REQ-011 mem_read_valid  output  1  request to shared backing memory.
REQ-012 mem_read_address  output  ADDR_BITS  address presented to memory.
REQ-013 mem_read_ready  input  1  memory completion strobe.
REQ-014 mem_read_data  input  DATA_BITS  memory return word, valid when mem_read_ready=1.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 grant_id  output  ID_BITS  index of channel currently/last granted.

Function
REQ-017 FSM states IDLE, REQUEST, RESPOND; all outputs driven from registers.
REQ-018 IDLE: if any cache_read_valid bit set, grant one channel at the clock edge, latch its address into mem_read_address, set grant_id, go REQUEST; else stay IDLE.
REQ-019 Arbitration round-robin: search channels starting at rr_ptr, ascending, wrapping NUM_CHANNELS-1 -> 0; first set bit wins.
REQ-020 On grant to channel k, rr_ptr <= (k+1) mod NUM_CHANNELS; rr_ptr unchanged otherwise.
REQ-021 REQUEST: mem_read_valid=1, mem_read_address held stable; cache_read_valid changes ignored.
REQ-022 REQUEST with mem_read_ready=1: latch mem_read_data into data register, go RESPOND; otherwise remain (no timeout).
REQ-023 RESPOND: exactly one cycle; mem_read_valid=0, cache_read_ready[grant_id]=1, all other ready bits 0; next state IDLE.
REQ-024 mem_read_ready is ignored in IDLE and RESPOND (covers memories that return a trailing strobe one cycle after valid drops).
REQ-025 Every lane of cache_read_data carries the data register; only cache_read_ready qualifies it.
REQ-026 Minimum latency: valid seen in IDLE at edge E0 -> mem_read_valid high after E0 -> with 1-cycle memory, ready pulse in cycle after E2; 3 cycles request-to-ready.
REQ-027 Requesters hold valid and address stable until their ready pulse and drop valid at the edge sampling it; a channel dropping valid while granted still receives completion.
REQ-028 At most one cache_read_ready bit is high in any cycle; mem_read_valid never high in RESPOND or IDLE.
REQ-029 Simultaneous requests from all channels are served in rotation; no channel waits more than NUM_CHANNELS grants.

Reset
REQ-030 While reset=1 at an edge: state<=IDLE, rr_ptr<=0, grant_id<=0, data register<=0, mem_read_address<=0.
REQ-031 Reset output values: mem_read_valid=0, cache_read_ready=0, cache_read_data=0, busy=0.
REQ-032 Reset asserted in REQUEST or RESPOND aborts the transaction; no ready pulse is issued for it and a memory strobe arriving afterward is ignored.

Verification
REQ-033 Memory model returns 2*addr+1 one cycle after valid; ch0 requests 0x05 alone -> mem_read_address=0x05, cache_read_ready=4'b0001 with lane0 data 0x000B, 3 cycles after request.
REQ-034 Channels 0-3 request 0x10,0x20,0x30,0x40 in the same cycle after reset -> grants in order 0,1,2,3; data 0x0021,0x0041,0x0061,0x0081; never two ready bits high.
REQ-035 ch2 served, then ch1 and ch3 request together -> ch3 granted first (rr_ptr=3), then ch1.
REQ-036 Memory holds mem_read_ready low 5 cycles in REQUEST -> mem_read_valid stays high, address stable, busy=1; ready pulse one cycle after strobe.
REQ-037 Reset asserted while in REQUEST -> busy=0 and mem_read_valid=0 the next cycle; no cache_read_ready pulse; next request granted from channel 0 search.
REQ-038 Memory returns trailing strobe during RESPOND -> ignored; arbiter reaches IDLE and issues no extra ready pulse.
